tap_data_path: RTL and testbench
================================

# tap_data_path

Scan data path driven by the TAP controller's `STATE` output: it owns the 4-bit instruction register, the BYPASS, IDCODE and USER data registers, and the TDO output mux. Each rising TCLK edge performs the capture, shift or update action of the state currently presented on `STATE`. It sits directly downstream of the TAP controller in the JTAG/DFT subsystem and drives the chip-level TDO pin and the user-register update interface.

## Interface
- `IDCODE_VALUE`, default 32'h1A5C_0ACF: value captured into IDCODE; bit 0 must be 1.
- `USER_WIDTH`, default 8: width of the USER data register (≥2).
- `TCLK` input 1: test clock; all flops on rising edge.
- `TRST` input 1: reset, asynchronous, active-low.
- `STATE` input 4: TAP state (0 TLR, 1 RTI, 2 SelDR, 3 CapDR, 4 ShDR, 5 Ex1DR, 6 PauDR, 7 Ex2DR, 8 UpdDR, 9 SelIR, 10 CapIR, 11 ShIR, 12 Ex1IR, 13 PauIR, 14 Ex2IR, 15 UpdIR).
- `TDI` input 1: serial scan input.
- `USER_DIN` input USER_WIDTH: parallel value captured into USER in CapDR.
- `TDO` output 1: serial scan output.
- `TDO_EN` output 1: high only in ShDR/ShIR.
- `IR_OUT` output 4: current (updated) instruction.
- `USER_DOUT` output USER_WIDTH: USER update register.
- `USER_UPDATE` output 1: one-cycle pulse on a USER update.

## Operation
- Instructions: 4'b0001 IDCODE, 4'b0010 USER, 4'b1111 BYPASS; every other code selects BYPASS.
- Registers: IR shift reg (4), IR (4), BYPASS (1), IDCODE shift reg (32), USER shift reg (USER_WIDTH), USER_DOUT (USER_WIDTH).
- Selected DR is decoded from IR (the updated value), never from the IR shift reg.
- Actions at the rising edge of TCLK, keyed on `STATE`:
  - TLR: IR <= 4'b0001 (IDCODE). Shift regs hold.
  - CapIR: IR shift reg <= 4'b0101.
  - ShIR: IR shift reg <= {TDI, irsr[3:1]} (LSB first, TDI enters MSB).
  - UpdIR: IR <= IR shift reg.
  - CapDR: selected DR captures: BYPASS <= 0; IDCODE sr <= IDCODE_VALUE; USER sr <= USER_DIN.
  - ShDR: selected DR shifts right, TDI into MSB (BYPASS <= TDI). Unselected DRs hold.
  - UpdDR with USER selected: USER_DOUT <= USER sr; USER_UPDATE <= 1 for exactly that next cycle. Any other state/instruction: USER_UPDATE <= 0.
  - RTI, Sel*, Ex1*, Ex2*, Pau*: all registers hold.
- TDO is combinational from registered values. In ShIR it is irsr[0]. In ShDR it is bit 0 of the selected DR. Otherwise TDO=0, TDO_EN=0.
- Pause/Exit states preserve shift reg contents, so a shift resumed via Ex2→Sh continues seamlessly.

## Timing
- TRST low (async, any time, including mid-shift): IR=4'b0001; IR sr, BYPASS, IDCODE sr, USER sr = 0; USER_DOUT=0; USER_UPDATE=0. Consequently TDO=0 and TDO_EN=0 while STATE≠Sh*.
- Release is synchronous to TCLK; the first active edge after TRST rises acts on `STATE`.
- Capture→shift: the captured bit 0 appears on TDO while STATE=Sh*, before the first shift edge. Each subsequent edge in Sh* advances TDO by one bit.
- BYPASS: one-cycle TDI→TDO delay.
- USER_UPDATE asserts in the cycle after the UpdDR edge, concurrently with the new USER_DOUT. It is never high two consecutive cycles; UpdDR lasts one state.
- A new IR value takes effect for DR selection from the edge after UpdIR. Holding in UpdIR is impossible since the controller always leaves it, but repeated UpdIR edges would be idempotent.
- Shift length is unbounded. Bits shifted beyond the register width fall off the LSB; the last N TDI bits remain.
- STATE values are not checked; all 16 codes are legal.

## Test plan
- Reset: assert TRST low mid-ShDR with USER sr=8'hA5 → immediately IR_OUT=4'b0001, USER_DOUT=0, USER_UPDATE=0, TDO=0; after release, TLR edge keeps IR=0001.
- IDCODE read: TLR→RTI→SelDR→CapDR→32×ShDR with TDI=0 → TDO sequence LSB-first equals 32'h1A5C_0ACF; first bit is 1.
- IR capture/load: CapIR→ShIR×4 with TDI bits 0,1,0,0 (LSB first) → TDO shows 1,0,1,0; after UpdIR, IR_OUT=4'b0010.
- USER write/read: IR=USER, USER_DIN=8'h3C, CapDR, shift in 8'hC3 via 8×ShDR → TDO emits 8'h3C LSB-first; after UpdDR, USER_DOUT=8'hC3 and USER_UPDATE is a single one-cycle pulse.
- BYPASS/illegal opcode: load IR=4'b0110, CapDR then ShDR with TDI pattern 1,0,1,1 → TDO shows 0,1,0,1 (one-cycle delay); USER_DOUT unchanged and no USER_UPDATE on UpdDR.
- Pause resume: USER shift 3 bits, Ex1DR→PauDR×5→Ex2DR→ShDR for 5 bits → USER_DOUT after UpdDR equals the 8 TDI bits as if shifted contiguously.

Source files
------------

// File: rtl/tap_data_path_if.sv
// Scan-side bundle between the TAP controller / test logic and the scan data
// path: state and serial input in, serial output, instruction and USER
// register update interface out.
interface tap_data_path_if #(
    parameter int USER_WIDTH = 8
);
    logic [3:0]            STATE;
    logic                  TDI;
    logic [USER_WIDTH-1:0] USER_DIN;
    logic                  TDO;
    logic                  TDO_EN;
    logic [3:0]            IR_OUT;
    logic [USER_WIDTH-1:0] USER_DOUT;
    logic                  USER_UPDATE;

    // Controller / test side
    modport master (
        output STATE, TDI, USER_DIN,
        input  TDO, TDO_EN, IR_OUT, USER_DOUT, USER_UPDATE
    );

    // Data path side
    modport slave (
        input  STATE, TDI, USER_DIN,
        output TDO, TDO_EN, IR_OUT, USER_DOUT, USER_UPDATE
    );
endinterface

// File: rtl/tap_data_path.sv
// JTAG scan data path: instruction register, BYPASS / IDCODE / USER data
// registers and the TDO mux. Every rising TCLK edge performs the capture,
// shift or update action of the TAP state presented on STATE.
module tap_data_path #(
    parameter logic [31:0] IDCODE_VALUE = 32'h1A5C_0ACF,
    parameter int          USER_WIDTH   = 8
) (
    input  logic            TCLK,
    input  logic            TRST,
    tap_data_path_if.slave  tap
);

    localparam logic [3:0] ST_TLR    = 4'd0;
    localparam logic [3:0] ST_CAPDR  = 4'd3;
    localparam logic [3:0] ST_SHDR   = 4'd4;
    localparam logic [3:0] ST_UPDDR  = 4'd8;
    localparam logic [3:0] ST_CAPIR  = 4'd10;
    localparam logic [3:0] ST_SHIR   = 4'd11;
    localparam logic [3:0] ST_UPDIR  = 4'd15;

    localparam logic [3:0] INS_IDCODE  = 4'b0001;
    localparam logic [3:0] INS_USER    = 4'b0010;
    localparam logic [3:0] IR_CAPTURE  = 4'b0101;

    logic [3:0]            irsr;
    logic [3:0]            ir;
    logic                  bypass_r;
    logic [31:0]           idsr;
    logic [USER_WIDTH-1:0] usersr;
    logic [USER_WIDTH-1:0] user_dout;
    logic                  user_upd;
    logic                  tdo;
    logic                  tdo_en;

    // DR selection follows the updated IR only; unknown opcodes fall to BYPASS.
    logic sel_idcode;
    logic sel_user;
    assign sel_idcode = (ir == INS_IDCODE);
    assign sel_user   = (ir == INS_USER);

    // Capture / shift / update actions of the presented TAP state.
    always_ff @(posedge TCLK or negedge TRST) begin
        if (!TRST) begin
            irsr      <= '0;
            ir        <= INS_IDCODE;
            bypass_r  <= 1'b0;
            idsr      <= '0;
            usersr    <= '0;
            user_dout <= '0;
            user_upd  <= 1'b0;
        end else begin
            user_upd <= 1'b0;
            case (tap.STATE)
                ST_TLR:   ir <= INS_IDCODE;
                ST_CAPIR: irsr <= IR_CAPTURE;
                ST_SHIR:  irsr <= {tap.TDI, irsr[3:1]};
                ST_UPDIR: ir <= irsr;
                ST_CAPDR: begin
                    if (sel_idcode)
                        idsr <= IDCODE_VALUE;
                    else if (sel_user)
                        usersr <= tap.USER_DIN;
                    else
                        bypass_r <= 1'b0;
                end
                ST_SHDR: begin
                    if (sel_idcode)
                        idsr <= {tap.TDI, idsr[31:1]};
                    else if (sel_user)
                        usersr <= {tap.TDI, usersr[USER_WIDTH-1:1]};
                    else
                        bypass_r <= tap.TDI;
                end
                ST_UPDDR: begin
                    if (sel_user) begin
                        user_dout <= usersr;
                        user_upd  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // TDO is driven only while shifting; bit 0 of the active shift register.
    always_comb begin
        tdo    = 1'b0;
        tdo_en = 1'b0;
        if (tap.STATE == ST_SHIR) begin
            tdo    = irsr[0];
            tdo_en = 1'b1;
        end else if (tap.STATE == ST_SHDR) begin
            tdo_en = 1'b1;
            if (sel_idcode)
                tdo = idsr[0];
            else if (sel_user)
                tdo = usersr[0];
            else
                tdo = bypass_r;
        end
    end

    assign tap.TDO         = tdo;
    assign tap.TDO_EN      = tdo_en;
    assign tap.IR_OUT      = ir;
    assign tap.USER_DOUT   = user_dout;
    assign tap.USER_UPDATE = user_upd;

endmodule

// File: tb/tb_tap_data_path.sv
// Directed bench for tap_data_path: reset, IDCODE read, IR load, USER
// write/read, BYPASS via illegal opcode, pause/resume and mid-shift reset.
module tb_tap_data_path;

    localparam logic [3:0] TLR = 4'd0, RTI = 4'd1, SELDR = 4'd2, CAPDR = 4'd3,
                           SHDR = 4'd4, EX1DR = 4'd5, PAUDR = 4'd6, EX2DR = 4'd7,
                           UPDDR = 4'd8, SELIR = 4'd9, CAPIR = 4'd10, SHIR = 4'd11,
                           EX1IR = 4'd12, UPDIR = 4'd15;

    logic TCLK;
    logic TRST;
    int   checks;
    int   failures;

    tap_data_path_if #(.USER_WIDTH(8)) tap ();

    tap_data_path #(.IDCODE_VALUE(32'h1A5C_0ACF), .USER_WIDTH(8)) dut (
        .TCLK (TCLK),
        .TRST (TRST),
        .tap  (tap)
    );

    initial TCLK = 1'b0;
    always #5 TCLK = ~TCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a state, let one rising edge act on it, settle 1 time unit.
    task automatic step(input logic [3:0] st, input logic tdi);
        tap.STATE = st;
        tap.TDI   = tdi;
        @(posedge TCLK);
        #1;
    endtask

    // Shift one bit, checking TDO/TDO_EN before the shifting edge.
    task automatic shift(input logic [3:0] st, input logic tdi, input logic exp_tdo, input string tag);
        tap.STATE = st;
        tap.TDI   = tdi;
        #1;
        chk(tag, tap.TDO, exp_tdo);
        chk({tag, "_en"}, tap.TDO_EN, 1'b1);
        @(posedge TCLK);
        #1;
    endtask

    // Load a 4-bit instruction, LSB first; capture value 0101 seen on TDO.
    task automatic load_ir(input logic [3:0] ins);
        logic [3:0] cap;
        cap = 4'b0101;
        step(SELDR, 1'b0);
        step(SELIR, 1'b0);
        step(CAPIR, 1'b0);
        for (int i = 0; i < 4; i++) shift(SHIR, ins[i], cap[i], "ir_cap_tdo");
        step(EX1IR, 1'b0);
        step(UPDIR, 1'b0);
        chk("ir_out", tap.IR_OUT, ins);
    endtask

    logic [31:0] idv;
    logic [7:0]  wr;
    logic [7:0]  rd;
    logic [3:0]  bpat;
    logic [3:0]  bexp;

    initial begin
        checks   = 0;
        failures = 0;
        idv      = 32'h1A5C_0ACF;
        TRST     = 1'b0;
        tap.STATE    = TLR;
        tap.TDI      = 1'b0;
        tap.USER_DIN = 8'h00;
        #12;
        chk("rst_ir", tap.IR_OUT, 4'b0001);
        chk("rst_udout", tap.USER_DOUT, 8'h00);
        chk("rst_uupd", tap.USER_UPDATE, 1'b0);
        chk("rst_tdo", tap.TDO, 1'b0);
        chk("rst_tdoen", tap.TDO_EN, 1'b0);
        TRST = 1'b1;

        // IDCODE read, TDI=0
        step(TLR, 1'b0);
        chk("tlr_ir", tap.IR_OUT, 4'b0001);
        step(RTI, 1'b0);
        step(SELDR, 1'b0);
        step(CAPDR, 1'b0);
        for (int i = 0; i < 32; i++) shift(SHDR, 1'b0, idv[i], "idcode_tdo");
        step(EX1DR, 1'b0);
        chk("ex1dr_tdoen", tap.TDO_EN, 1'b0);
        step(UPDDR, 1'b0);
        chk("idcode_no_upd", tap.USER_UPDATE, 1'b0);
        step(RTI, 1'b0);

        // IR capture/load of USER (TDI 0,1,0,0 -> TDO 1,0,1,0)
        load_ir(4'b0010);
        step(RTI, 1'b0);

        // USER write/read
        tap.USER_DIN = 8'h3C;
        wr = 8'hC3;
        rd = 8'h3C;
        step(SELDR, 1'b0);
        step(CAPDR, 1'b0);
        for (int i = 0; i < 8; i++) shift(SHDR, wr[i], rd[i], "user_tdo");
        step(EX1DR, 1'b0);
        chk("user_pre_upd", tap.USER_UPDATE, 1'b0);
        chk("user_pre_dout", tap.USER_DOUT, 8'h00);
        step(UPDDR, 1'b0);
        chk("user_dout", tap.USER_DOUT, 8'hC3);
        chk("user_upd_pulse", tap.USER_UPDATE, 1'b1);
        step(RTI, 1'b0);
        chk("user_upd_drop", tap.USER_UPDATE, 1'b0);
        chk("user_dout_hold", tap.USER_DOUT, 8'hC3);

        // BYPASS via illegal opcode 0110
        load_ir(4'b0110);
        bpat = 4'b1101;   // TDI sequence 1,0,1,1 (LSB first)
        bexp = 4'b1010;   // TDO sequence 0,1,0,1
        step(SELDR, 1'b0);
        step(CAPDR, 1'b1);
        for (int i = 0; i < 4; i++) shift(SHDR, bpat[i], bexp[i], "bypass_tdo");
        step(EX1DR, 1'b0);
        step(UPDDR, 1'b0);
        chk("bypass_no_upd", tap.USER_UPDATE, 1'b0);
        chk("bypass_dout", tap.USER_DOUT, 8'hC3);
        step(RTI, 1'b0);

        // Pause/resume USER shift of 8'h96
        load_ir(4'b0010);
        tap.USER_DIN = 8'h00;
        wr = 8'h96;
        step(SELDR, 1'b0);
        step(CAPDR, 1'b0);
        for (int i = 0; i < 3; i++) shift(SHDR, wr[i], 1'b0, "pause_tdo");
        step(EX1DR, 1'b0);
        for (int i = 0; i < 5; i++) step(PAUDR, 1'b1);
        chk("pause_tdo_idle", tap.TDO, 1'b0);
        chk("pause_tdoen_idle", tap.TDO_EN, 1'b0);
        step(EX2DR, 1'b1);
        for (int i = 3; i < 8; i++) shift(SHDR, wr[i], 1'b0, "resume_tdo");
        step(EX1DR, 1'b0);
        step(UPDDR, 1'b0);
        chk("pause_dout", tap.USER_DOUT, 8'h96);
        chk("pause_upd", tap.USER_UPDATE, 1'b1);
        step(RTI, 1'b0);
        chk("pause_upd_drop", tap.USER_UPDATE, 1'b0);

        // Async reset mid-ShDR with USER sr = A5
        tap.USER_DIN = 8'hA5;
        step(SELDR, 1'b0);
        step(CAPDR, 1'b0);
        tap.STATE = SHDR;
        tap.TDI   = 1'b0;
        #1;
        chk("midshift_tdo", tap.TDO, 1'b1);
        TRST = 1'b0;
        #1;
        chk("arst_ir", tap.IR_OUT, 4'b0001);
        chk("arst_udout", tap.USER_DOUT, 8'h00);
        chk("arst_uupd", tap.USER_UPDATE, 1'b0);
        chk("arst_tdo", tap.TDO, 1'b0);
        tap.STATE = TLR;
        #1;
        TRST = 1'b1;
        step(TLR, 1'b0);
        chk("post_rst_ir", tap.IR_OUT, 4'b0001);
        chk("post_rst_tdo", tap.TDO, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
